// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder producing sum, carry-out and signed overflow
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 result bits already produced; the last bit is joined
    // on the fly when the result is loaded into sum.
    logic [WIDTH-2:0] r_sh_q, r_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] res_next;

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and one-bit full-add step; carry_q is the carry into the
    // current bit, so at the MSB step carry_q ^ bit_c is the signed overflow.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        bit_c    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_next = {bit_s, r_sh_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                r_sh_d  = res_next[WIDTH-1:1];
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_next;
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow means the signed result
    // does not fit in W bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int ux, uy, sx, sy, us, ss;
        logic ov;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        us = ux + uy + int'(c);
        ss = sx + sy + int'(c);
        ov = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
        return {ov, (us >= (1 << W)), W'(us % (1 << W))};
    endfunction

    // One operation: start for one cycle, scramble inputs, optionally poke a
    // second start at RUN cycle poke_k, then wait for done and check it.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input int poke_k);
        logic [W+1:0] exp;
        int busy_cnt;
        int lat;
        exp = model(x, y, c);
        @(negedge clk);
        start = 1'b1; a = x; b = y; cin = c;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        busy_cnt = 0;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (k == poke_k) begin
                start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
            check({tag, "_hold"}, {ovf_or(overflow), cout, sum}, {prev_ovf, prev_cout, prev_sum});
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(W));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, "_result"}, {overflow, cout, sum}, exp);
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
        prev_ovf  = exp[W+1];
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    function automatic logic ovf_or(input logic v);
        return v;
    endfunction

    // Watch for stray done pulses for n cycles.
    task automatic no_done(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'(0));
    endtask

    initial begin
        int times[$];
        logic [W-1:0] rx, ry;
        logic rc;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {overflow, cout, sum, busy, done}, '0);
        rst_n = 1'b1;

        run_op("5a_3c", 8'h5A, 8'h3C, 1'b0, -1);
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, -1);
        run_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, -1);
        run_op("7f_00_c", 8'h7F, 8'h00, 1'b1, -1);
        run_op("ignore_start", 8'h01, 8'h01, 1'b0, 3);
        no_done("ignore_no_second", 12);

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", {overflow, cout, sum, busy, done}, '0);
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        no_done("abort_no_done", 12);
        run_op("10_20", 8'h10, 8'h20, 1'b0, -1);

        // Start held high: one done every W+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        for (int t = 0; t < 45; t++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(t);
                check("b2b_sum", {overflow, cout, sum}, {2'b00, 8'h03});
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(times.size()), 64'(4));
        for (int i = 1; i < times.size(); i++)
            check("b2b_period", 64'(times[i] - times[i-1]), 64'(W + 2));
        repeat (12) @(negedge clk);
        prev_sum = 8'h03; prev_cout = 1'b0; prev_ovf = 1'b0;

        for (int n = 0; n < 30; n++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            rc = 1'($urandom);
            run_op("random", rx, ry, rc, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
